imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader and write master for the instruction memory.
//  - Takes a byte stream (UART/debug bridge) over a valid/ready handshake.
//  - Packs bytes little-endian into 32-bit words.
//  - Drives the IMEM write port (Inst_in, Addr_64, IMEM_WE) at incrementing word addresses.
//  - Holds the core in reset via cpu_hold until the image is fully written.
// PARAMETERS
//  WORD_BITS    32     instruction word width (= `WORD_BITS)
//  DATA_BITS    64     address bus width (= `DATA_BITS)
//  DEPTH_WORDS  4096   IMEM capacity in words; IMEM indexes Addr_64[13:2]
//  BASE_ADDR    64'h0  byte address of the first word written, 4-byte aligned
// PORTS
//  CLK           in   1          system clock, all logic on posedge
//  RST_N         in   1          asynchronous active-low reset
//  start         in   1          1-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERR
//  rx_data       in   8          stream byte
//  rx_valid      in   1          rx_data is valid
//  rx_ready      out  1          loader accepts a byte this cycle
//  Inst_in       out  WORD_BITS  word to IMEM (registered)
//  Addr_64       out  DATA_BITS  IMEM byte address (registered, word aligned)
//  IMEM_WE       out  1          IMEM write strobe, 1 cycle per word
//  busy          out  1          high in LEN, DATA, WRITE
//  done          out  1          level; high in DONE
//  err           out  1          level; high in ERR
//  cpu_hold      out  1          core reset request; low only in DONE
//  words_written out  13         count of words committed in the current load
// BEHAVIOUR
//  Reset (async, RST_N=0):
//   - State goes to IDLE.
//   - All outputs 0 except cpu_hold=1.
//   - Internal byte counter, word counter and length are cleared.
//   - IMEM contents are not touched; a partial image may remain.
//  Byte transfer: occurs only on a posedge where rx_valid && rx_ready.
//   - rx_ready=1 only in LEN and DATA.
//  States:
//   - IDLE:  start -> LEN; clear words_written, byte_cnt and len.
//   - LEN:   accept 4 bytes, little-endian, giving word count N.
//     - On the 4th byte: N==0 -> DONE; N>DEPTH_WORDS -> ERR; otherwise -> DATA.
//   - DATA:  accept 4 bytes into a word, little-endian (1st byte = bits 7:0).
//     - On the 4th byte, register Inst_in and Addr_64 = BASE_ADDR + 4*words_written, then go to WRITE.
//   - WRITE: exactly 1 cycle. IMEM_WE=1, rx_ready=0.
//     - words_written increments at the end of the cycle.
//     - If the new count == N -> DONE, else -> DATA.
//   - DONE:  done=1, cpu_hold=0. start -> LEN (reload, cpu_hold returns to 1).
//   - ERR:   err=1, rx_ready=0, no writes. start -> LEN.
//  Output timing:
//   - IMEM_WE is high in the WRITE state only; it is never high in any other state.
//   - Inst_in and Addr_64 hold their last values outside WRITE.
//  Throughput: a load takes at least 4 + 5N cycles from the first length byte to DONE.
//  Boundaries:
//   - start asserted while busy: ignored.
//   - rx_valid gaps: the loader waits indefinitely; there is no timeout.
//   - N == DEPTH_WORDS is legal; the last address is BASE_ADDR + 4*(DEPTH_WORDS-1).
//   - Byte counter wraps 3 -> 0 at each word boundary.
//   - Bytes presented in IDLE, WRITE, DONE or ERR are not consumed (rx_ready=0).
// TESTING
//  1. Reset: RST_N low mid-sim -> IMEM_WE/busy/done/err/rx_ready=0, cpu_hold=1, words_written=0.
//  2. start; bytes 02 00 00 00 78 56 34 12 EF BE AD DE -> writes 0x12345678@0x0 and 0xDEADBEEF@0x4;
//     done=1, cpu_hold=0, words_written=2.
//  3. Length 00 00 00 00 -> DONE on the cycle after the 4th byte; IMEM_WE never asserted.
//  4. Length 01 10 00 00 (4097) -> err=1, rx_ready=0, no IMEM_WE; a following start plus a valid image recovers.
//  5. Random rx_valid gaps with N=16 -> IMEM readback matches the image;
//     rx_ready=0 in every WRITE cycle; exactly 16 IMEM_WE pulses.
//  6. RST_N pulsed after 2 of 4 words -> IDLE, cpu_hold=1; start pulse mid-load is ignored;
//     a subsequent full load completes correctly.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: packs a little-endian byte stream into words and writes them
// to instruction memory, holding the core in reset until the image is loaded.
module imem_loader #(
  parameter int unsigned WORD_BITS   = 32,
  parameter int unsigned DATA_BITS   = 64,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [DATA_BITS-1:0] BASE_ADDR = '0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [WORD_BITS-1:0] Inst_in,
  output logic [DATA_BITS-1:0] Addr_64,
  output logic                 IMEM_WE,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 cpu_hold,
  output logic [12:0]          words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  state_t                 state_q, state_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [31:0]            len_q, len_d;
  logic [23:0]            buf_q, buf_d;
  logic [WORD_BITS-1:0]   inst_q, inst_d;
  logic [DATA_BITS-1:0]   addr_q, addr_d;
  logic [12:0]            words_q, words_d;

  logic        fire;
  logic        last_byte;
  logic        can_start;
  logic [31:0] len_full;
  logic [12:0] words_inc;

  assign rx_ready  = (state_q == S_LEN) || (state_q == S_DATA);
  assign fire      = rx_valid && rx_ready;
  assign last_byte = (byte_cnt_q == 2'd3);
  assign len_full  = {rx_data, len_q[23:0]};
  assign words_inc = words_q + 13'd1;
  assign can_start = (state_q == S_IDLE) || (state_q == S_DONE) ||
                     (state_q == S_ERR);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    buf_d      = buf_q;
    inst_d     = inst_q;
    addr_d     = addr_q;
    words_d    = words_q;

    if (can_start && start) begin
      state_d    = S_LEN;
      byte_cnt_d = 2'd0;
      len_d      = '0;
      words_d    = '0;
    end else begin
      unique case (state_q)
        S_LEN: begin
          if (fire) begin
            len_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (last_byte) begin
              if (len_full == 32'd0) begin
                state_d = S_DONE;
              end else if (len_full > DEPTH_L) begin
                state_d = S_ERR;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (fire) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (last_byte) begin
              inst_d  = WORD_BITS'({rx_data, buf_q});
              addr_d  = BASE_ADDR + DATA_BITS'({words_q, 2'b00});
              state_d = S_WRITE;
            end else begin
              buf_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
            end
          end
        end
        S_WRITE: begin
          words_d = words_inc;
          if ({19'd0, words_inc} == len_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      len_q      <= '0;
      buf_q      <= '0;
      inst_q     <= '0;
      addr_q     <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      buf_q      <= buf_d;
      inst_q     <= inst_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
    end
  end

  assign Inst_in       = inst_q;
  assign Addr_64       = addr_q;
  assign IMEM_WE       = (state_q == S_WRITE);
  assign busy          = (state_q == S_LEN) || (state_q == S_DATA) ||
                         (state_q == S_WRITE);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign cpu_hold      = (state_q != S_DONE);
  assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with an expected-write scoreboard
// and a behavioural IMEM that captures every write strobe.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] Inst_in;
  logic [63:0] Addr_64;
  logic        IMEM_WE;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;
  logic [12:0] words_written;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;

  logic [95:0] sb_q[$];
  logic [31:0] mem [0:4095];
  logic [31:0] img [0:15];

  imem_loader dut (
    .CLK(CLK), .RST_N(RST_N), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .Inst_in(Inst_in), .Addr_64(Addr_64), .IMEM_WE(IMEM_WE),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold),
    .words_written(words_written)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // write monitor, sampled mid-cycle
  always @(negedge CLK) begin
    if (IMEM_WE === 1'b1) begin
      logic [95:0] e;
      we_cnt++;
      mem[Addr_64[13:2]] = Inst_in;
      chk("rx_ready_in_write", 64'(rx_ready), 64'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {Addr_64[31:0], Inst_in}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", Addr_64, e[95:32]);
        chk("wr_data", 64'(Inst_in), 64'(e[31:0]));
      end
    end
  end

  // entered just after a negedge; leaves just after the accepting posedge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) chk("rx_ready_timeout", 64'(n), 64'd0);
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (maxgap > 0) ? $urandom_range(maxgap, 0) : 0);
  endtask

  task automatic send_data(input logic [31:0] w, input logic [63:0] a,
                           input int maxgap);
    sb_q.push_back({a, w});
    send_word(w, maxgap);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (done !== 1'b1 && err !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, 64'(n), 64'd0);
  endtask

  task automatic do_reset;
    RST_N = 1'b0;
    #1;
    chk("rst_we", 64'(IMEM_WE), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("rst_words", 64'(words_written), 64'd0);
    chk("rst_addr", Addr_64, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    int base_we;
    @(negedge CLK);
    do_reset();

    // basic two-word image
    pulse_start();
    chk("len_busy", 64'(busy), 64'd1);
    chk("len_hold", 64'(cpu_hold), 64'd1);
    send_word(32'd2, 0);
    send_data(32'h1234_5678, 64'h0, 0);
    send_data(32'hDEAD_BEEF, 64'h4, 0);
    wait_end("t2");
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_hold", 64'(cpu_hold), 64'd0);
    chk("t2_words", 64'(words_written), 64'd2);
    chk("t2_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("t2_mem1", 64'(mem[1]), 64'hDEAD_BEEF);

    // zero length goes straight to DONE
    base_we = we_cnt;
    pulse_start();
    chk("t3_hold", 64'(cpu_hold), 64'd1);
    send_word(32'd0, 0);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_words", 64'(words_written), 64'd0);
    chk("t3_no_we", 64'(we_cnt - base_we), 64'd0);

    // oversize length (4097) errors out
    pulse_start();
    send_word(32'h0000_1001, 0);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_rx_ready", 64'(rx_ready), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    rx_data = 8'hAA;
    rx_valid = 1'b1;
    repeat (3) @(negedge CLK);
    rx_valid = 1'b0;
    chk("t4_still_err", 64'(err), 64'd1);
    chk("t4_no_we", 64'(we_cnt - base_we), 64'd0);
    pulse_start();
    send_word(32'd1, 0);
    send_data(32'hCAFE_F00D, 64'h0, 0);
    wait_end("t4r");
    chk("t4_recover", 64'(done), 64'd1);
    chk("t4_err_clr", 64'(err), 64'd0);

    // 16 words with random valid gaps
    base_we = we_cnt;
    for (int i = 0; i < 16; i++) img[i] = $urandom();
    pulse_start();
    send_word(32'd16, 3);
    for (int i = 0; i < 16; i++) send_data(img[i], 64'(4 * i), 3);
    wait_end("t5");
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_we_pulses", 64'(we_cnt - base_we), 64'd16);
    chk("t5_words", 64'(words_written), 64'd16);
    for (int i = 0; i < 16; i++) chk("t5_readback", 64'(mem[i]), 64'(img[i]));

    // reset mid-load, ignored start, then full reload
    pulse_start();
    send_word(32'd4, 0);
    send_data(32'h1111_1111, 64'h0, 0);
    pulse_start();
    chk("t6_start_ignored", 64'(busy), 64'd1);
    send_data(32'h2222_2222, 64'h4, 0);
    @(negedge CLK);
    chk("t6_words2", 64'(words_written), 64'd2);
    do_reset();
    chk("t6_idle_hold", 64'(cpu_hold), 64'd1);
    chk("t6_idle_busy", 64'(busy), 64'd0);
    pulse_start();
    send_word(32'd4, 0);
    for (int i = 0; i < 4; i++) send_data(32'hA5A5_0000 + 32'(i), 64'(4 * i), 1);
    wait_end("t6");
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_words", 64'(words_written), 64'd4);
    chk("t6_mem3", 64'(mem[3]), 64'hA5A5_0003);

    // full-depth image
    base_we = we_cnt;
    pulse_start();
    send_word(32'd4096, 0);
    for (int i = 0; i < 4096; i++)
      send_data(32'(i) * 32'h9E37_79B1, 64'(4 * i), 0);
    wait_end("t7");
    chk("t7_done", 64'(done), 64'd1);
    chk("t7_words", 64'(words_written), 64'd4096);
    chk("t7_last_addr", Addr_64, 64'h3FFC);
    chk("t7_we_pulses", 64'(we_cnt - base_we), 64'd4096);
    chk("t7_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
